// File: rtl/distram_fifo_prog_pkg.sv
// Shared sizing helpers, latency limits and threshold defaults for distram_fifo_prog.
package distram_fifo_prog_pkg;

    localparam int RD_LATENCY_MIN       = 1;
    localparam int RD_LATENCY_MAX       = 2;
    localparam int DEFAULT_AE_THRESHOLD = 2;

    function automatic int FIFO_CNT_W(input int d);
        return d + 1;
    endfunction

    function automatic int default_af_threshold(input int depth_bits);
        return (1 << depth_bits) - 4;
    endfunction

endpackage

// File: rtl/distram_fifo_prog_2port.sv
// Distributed-RAM storage: one synchronous write port, one asynchronous read port.
module distram_2port
    import distram_fifo_prog_pkg::*;
#(
    parameter int DATA_WIDTH      = 64,
    parameter int DEPTH_BIT_WIDTH = 5
) (
    input  logic                       clk,
    input  logic                       we,
    input  logic [DEPTH_BIT_WIDTH-1:0] waddr,
    input  logic [DATA_WIDTH-1:0]      din,
    input  logic [DEPTH_BIT_WIDTH-1:0] raddr,
    output logic [DATA_WIDTH-1:0]      dout
);

    logic [DATA_WIDTH-1:0] mem [2**DEPTH_BIT_WIDTH];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= din;
    end

    assign dout = mem[raddr];

endmodule

// File: rtl/distram_fifo_prog.sv
// Programmable distributed-RAM FIFO with 1/2-stage read latency and sticky error flags.
// Define DISTRAM_FIFO_FWFT_EN for first-word-fall-through mode (head register, RD_LATENCY ignored).
module distram_fifo_prog
    import distram_fifo_prog_pkg::*;
#(
    parameter int FIFO_WIDTH                 = 64,
    parameter int FIFO_DEPTH_BITS            = 5,
    parameter int FIFO_ALMOSTFULL_THRESHOLD  = default_af_threshold(FIFO_DEPTH_BITS),
    parameter int FIFO_ALMOSTEMPTY_THRESHOLD = DEFAULT_AE_THRESHOLD,
    parameter int RD_LATENCY                 = 1
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     we,
    input  logic [FIFO_WIDTH-1:0]    din,
    output logic                     full,
    output logic                     almostfull,
    input  logic                     re,
    output logic                     valid,
    output logic [FIFO_WIDTH-1:0]    dout,
    output logic                     empty,
    output logic                     almostempty,
    output logic [FIFO_DEPTH_BITS:0] count,
    input  logic                     err_clr,
    output logic                     overflow,
    output logic                     underflow
);

    localparam int CW = FIFO_CNT_W(FIFO_DEPTH_BITS);
    localparam logic [CW-1:0] AF_TH = CW'(FIFO_ALMOSTFULL_THRESHOLD);
    localparam logic [CW-1:0] AE_TH = CW'(FIFO_ALMOSTEMPTY_THRESHOLD);

    if (RD_LATENCY < RD_LATENCY_MIN || RD_LATENCY > RD_LATENCY_MAX) begin : g_bad_latency
        $error("distram_fifo_prog: RD_LATENCY must be 1 or 2");
    end

    logic [CW-1:0]         wr_ptr;
    logic [CW-1:0]         rd_ptr;
    logic [CW-1:0]         count_q;
    logic [CW-1:0]         count_nxt;
    logic                  ram_empty;
    logic                  wr_acc;
    logic                  rd_acc;
    logic                  pop;
    logic                  ovf_evt;
    logic                  unf_evt;
    logic [FIFO_WIDTH-1:0] ram_rdata;

    assign ram_empty = (wr_ptr == rd_ptr);

    distram_2port #(
        .DATA_WIDTH      (FIFO_WIDTH),
        .DEPTH_BIT_WIDTH (FIFO_DEPTH_BITS)
    ) u_ram (
        .clk   (clk),
        .we    (wr_acc),
        .waddr (wr_ptr[FIFO_DEPTH_BITS-1:0]),
        .din   (din),
        .raddr (rd_ptr[FIFO_DEPTH_BITS-1:0]),
        .dout  (ram_rdata)
    );

`ifdef DISTRAM_FIFO_FWFT_EN
    localparam logic [CW-1:0] CAPACITY = CW'(1 << FIFO_DEPTH_BITS);

    logic                  head_valid;
    logic [FIFO_WIDTH-1:0] head_data;

    // count includes the head word, so capacity is judged on count rather than on the RAM pointers
    assign full    = (count_q == CAPACITY);
    assign empty   = ~head_valid;
    assign wr_acc  = we & ~full;
    assign pop     = re & head_valid;
    assign rd_acc  = ~ram_empty & (~head_valid | pop);
    assign ovf_evt = we & full;
    assign unf_evt = re & ~head_valid;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            head_valid <= 1'b0;
            head_data  <= '0;
        end else if (rd_acc) begin
            head_valid <= 1'b1;
            head_data  <= ram_rdata;
        end else if (pop) begin
            head_valid <= 1'b0;
        end
    end

    assign valid = head_valid;
    assign dout  = head_data;
`else
    logic                  v1;
    logic [FIFO_WIDTH-1:0] d1;

    assign full    = (wr_ptr[FIFO_DEPTH_BITS-1:0] == rd_ptr[FIFO_DEPTH_BITS-1:0]) &&
                     (wr_ptr[FIFO_DEPTH_BITS] != rd_ptr[FIFO_DEPTH_BITS]);
    assign empty   = ram_empty;
    assign wr_acc  = we & ~full;
    assign rd_acc  = re & ~ram_empty;
    assign pop     = rd_acc;
    assign ovf_evt = we & full;
    assign unf_evt = re & ram_empty;

    // data registers only load alongside their valid so dout holds between reads
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            v1 <= 1'b0;
            d1 <= '0;
        end else begin
            v1 <= rd_acc;
            if (rd_acc) d1 <= ram_rdata;
        end
    end

    if (RD_LATENCY == 2) begin : g_lat2
        logic                  v2;
        logic [FIFO_WIDTH-1:0] d2;

        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                v2 <= 1'b0;
                d2 <= '0;
            end else begin
                v2 <= v1;
                if (v1) d2 <= d1;
            end
        end

        assign valid = v2;
        assign dout  = d2;
    end else begin : g_lat1
        assign valid = v1;
        assign dout  = d1;
    end
`endif

    always_comb begin
        count_nxt = count_q;
        if (wr_acc && !pop)      count_nxt = count_q + CW'(1);
        else if (!wr_acc && pop) count_nxt = count_q - CW'(1);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count_q     <= '0;
            almostfull  <= 1'b0;
            almostempty <= 1'b1;
        end else begin
            if (wr_acc) wr_ptr <= wr_ptr + CW'(1);
            if (rd_acc) rd_ptr <= rd_ptr + CW'(1);
            count_q     <= count_nxt;
            almostfull  <= (count_nxt > AF_TH);
            almostempty <= (count_nxt <= AE_TH);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (ovf_evt)      overflow <= 1'b1;
            else if (err_clr) overflow <= 1'b0;
            if (unf_evt)      underflow <= 1'b1;
            else if (err_clr) underflow <= 1'b0;
        end
    end

    assign count = count_q;

endmodule

// File: doc/distram_fifo_prog.md
Name: distram_fifo_prog

Overview:
- Parametrised successor of the distributed-RAM FIFO for the operator datapaths.
- Uses the full 2**FIFO_DEPTH_BITS capacity, with a true full flag and a wide count.
- Adds selectable read latency (1 or 2 stages), programmable almostfull/almostempty, and sticky overflow/underflow error flags.
- Sits between memory-read engines and the compute pipelines wherever shallow LUT-RAM buffering with backpressure is needed.

Parameters:
FIFO_WIDTH, 64, data word width in bits
FIFO_DEPTH_BITS, 5, log2 of capacity (capacity = 2**FIFO_DEPTH_BITS entries)
FIFO_ALMOSTFULL_THRESHOLD, 2**FIFO_DEPTH_BITS-4, almostfull asserted when count > threshold
FIFO_ALMOSTEMPTY_THRESHOLD, 2, almostempty asserted when count <= threshold
RD_LATENCY, 1, cycles from accepted read to valid/dout; legal values 1 or 2

Ports:
clk  in  1  clock
reset_n  in  1  asynchronous active-low reset; applies to all state
we  in  1  write request
din  in  FIFO_WIDTH  write data
full  out  1  no free entry
almostfull  out  1  count > FIFO_ALMOSTFULL_THRESHOLD, registered
re  in  1  read request (pop acknowledge in FWFT mode)
valid  out  1  dout qualifier
dout  out  FIFO_WIDTH  read data
empty  out  1  no readable entry
almostempty  out  1  count <= FIFO_ALMOSTEMPTY_THRESHOLD, registered
count  out  FIFO_DEPTH_BITS+1  occupancy, 0..2**FIFO_DEPTH_BITS
err_clr  in  1  synchronous clear of the error flags
overflow  out  1  sticky: a write was attempted while full
underflow  out  1  sticky: a read was attempted while empty

Behaviour:
- Reset (asynchronous, active-low): count=0, pointers=0, empty=1, almostempty=1, full=0, almostfull=0, valid=0, dout=0, overflow=0, underflow=0.
- Pointers are FIFO_DEPTH_BITS+1 wide, with the extra wrap bit.
  - empty: pointers equal.
  - full: low bits equal and MSBs differ.
  - Both flags are combinational from the registered pointers.
- Accept rules:
  - wr_acc = we & ~full.
  - rd_acc = re & ~empty.
  - Flags are evaluated on the current-cycle state.
- Simultaneous events:
  - At full, re&we: the read is accepted and the write is rejected (overflow set).
  - At empty, re&we: the write is accepted and the read is rejected (underflow set).
  - Otherwise both are accepted and count is unchanged.
- count: +1 on wr_acc only, -1 on rd_acc only, never wraps.
- almostfull and almostempty are registered from next-count, so they update on the same edge as count.
- Storage is written on the wr_acc edge; the read is asynchronous at rd_ptr.
  - A word written at edge E is readable in the cycle after E (empty deasserts after E).
- Standard mode read path:
  - RD_LATENCY=1: dout and valid are registered one edge after rd_acc.
  - RD_LATENCY=2: one additional register stage on both.
  - valid is a one-cycle pulse per accepted read; back-to-back reads give continuous valid.
  - dout holds its last value when valid=0.
- Error flags:
  - overflow set on we&full; underflow set on re&empty.
  - err_clr clears them; a set event in the same cycle wins over the clear.
- Pointer wrap-around is natural modulo 2**(FIFO_DEPTH_BITS+1); no special case.
- An illegal RD_LATENCY value stops elaboration with an error.

Optional Feature:
- Macro: DISTRAM_FIFO_FWFT_EN.
- Defined (first-word-fall-through mode):
  - A head register holds the oldest word; valid=1 whenever the head is occupied, and dout = head.
  - re while valid pops the head. The head refills from RAM in the same edge if RAM is non-empty.
  - empty = ~valid.
  - count includes the head word; capacity stays 2**FIFO_DEPTH_BITS, and full = (count == 2**FIFO_DEPTH_BITS).
  - A write to an empty FIFO sampled at edge E gives valid high after edge E+1.
  - RD_LATENCY is ignored; underflow = re & ~valid.
- Undefined: standard mode as described above.

Decomposition:
- Shared package holds:
  - FIFO_CNT_W(d) = d+1.
  - Latency legality constants.
  - Default threshold expressions.
- One sub-module: distram_2port (1 write port, 1 asynchronous read port, DATA_WIDTH, DEPTH_BIT_WIDTH).
- The output pipeline and FWFT head logic live in the top module.

Test Plan (defaults: width 64, depth 32, AF 28, AE 2):
- Fill test: write 32 words 0..31 with re=0 -> full=1 after the 32nd edge, count=32, almostfull=1 from count=29. A 33rd write leaves count at 32 and sets overflow=1.
- Drain test (RD_LATENCY=1): read all 32 -> valid pulses with dout 0..31 in order, each one cycle after rd_acc. Then empty=1, almostempty=1 from count<=2, and one extra re sets underflow=1.
- Simultaneous full: at count=32, re&we -> count=32→31, the written word is dropped, overflow=1.
- Simultaneous empty: at count=0, re&we -> count=1 and underflow=1. The following read returns the written word.
- Wrap test with RD_LATENCY=2: 100 words streamed at random we/re -> order preserved, valid exactly 2 cycles after each rd_acc. Also: err_clr clears the flags, and an error asserted in the same cycle keeps its flag set.
- Reset mid-stream at count=17 -> all outputs return to reset values immediately (asynchronous); the next write/read pair returns the new data.
- FWFT build: a single write -> valid=1 two edges later with dout=data; re pops and valid drops when the FIFO is empty.
